pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit_pkg.sv | 19 +
 rtl/pc_addr_chk.sv | 19 +
 rtl/pc_unit.sv | 103 ++++++++++
 tb/tb_pc_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// Shared CPU constants (also used by CP0 and instruction memory) and the
// next-PC source selector for the program counter unit.
package pc_unit_pkg;

    localparam logic [31:0] CPU_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] CPU_EXC_PC   = 32'h0000_4180;
    localparam logic [31:0] CPU_IM_LO    = 32'h0000_3000;
    localparam logic [31:0] CPU_IM_HI    = 32'h0000_6FFC;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_HOLD = 3'd1,
        SEL_BR   = 3'd2,
        SEL_PEND = 3'd3,
        SEL_EXC  = 3'd4,
        SEL_ERET = 3'd5
    } pc_sel_e;

endpackage

// File: rtl/pc_addr_chk.sv
// Combinational fetch-address check: flags word misalignment or an address
// outside the instruction memory window [IM_LO, IM_HI].
module pc_addr_chk #(
    parameter int              ADDR_W = 32,
    parameter logic [ADDR_W-1:0] IM_LO = '0,
    parameter logic [ADDR_W-1:0] IM_HI = '1
) (
    input  logic [ADDR_W-1:0] pc,
    output logic              adel
);

    logic misaligned_s;
    logic out_of_range_s;

    assign misaligned_s   = (pc[1:0] != 2'b00);
    assign out_of_range_s = (pc < IM_LO) || (pc > IM_HI);
    assign adel           = misaligned_s || out_of_range_s;

endmodule

// File: rtl/pc_unit.sv
// Program counter unit: sequential fetch, branch redirect with a one-entry
// buffer that survives stalls, exception entry and exception return.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC),
    parameter logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(CPU_EXC_PC),
    parameter logic [ADDR_W-1:0] IM_LO    = ADDR_W'(CPU_IM_LO),
    parameter logic [ADDR_W-1:0] IM_HI    = ADDR_W'(CPU_IM_HI)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              exc_req,
    input  logic              eret,
    input  logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              pending,
    output logic              adel
);

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pend_tgt_r;
    logic              pend_r;
    logic [ADDR_W-1:0] pc_next_s;
    logic [ADDR_W-1:0] pend_tgt_next_s;
    logic              pend_next_s;
    pc_sel_e           sel_s;

    assign pc_plus4 = pc_r + ADDR_W'(32'd4);
    assign PC       = pc_r;
    assign pending  = pend_r;

    // Priority select of the next-PC source and redirect buffer update.
    always_comb begin
        sel_s           = SEL_SEQ;
        pend_next_s     = 1'b0;
        pend_tgt_next_s = pend_tgt_r;
        if (exc_req) begin
            sel_s = SEL_EXC;
        end else if (eret) begin
            sel_s = SEL_ERET;
        end else if (!stall) begin
            // A fresh redirect in the release cycle supersedes the buffered one.
            if (br_valid) begin
                sel_s = SEL_BR;
            end else if (pend_r) begin
                sel_s = SEL_PEND;
            end else begin
                sel_s = SEL_SEQ;
            end
        end else begin
            sel_s       = SEL_HOLD;
            pend_next_s = pend_r || br_valid;
            if (br_valid) begin
                pend_tgt_next_s = br_target;
            end else begin
                pend_tgt_next_s = pend_tgt_r;
            end
        end
    end

    // Next-PC multiplexer driven by the selected source.
    always_comb begin
        pc_next_s = pc_plus4;
        case (sel_s)
            SEL_SEQ:  pc_next_s = pc_plus4;
            SEL_HOLD: pc_next_s = pc_r;
            SEL_BR:   pc_next_s = br_target;
            SEL_PEND: pc_next_s = pend_tgt_r;
            SEL_EXC:  pc_next_s = EXC_PC;
            SEL_ERET: pc_next_s = epc;
            default:  pc_next_s = pc_plus4;
        endcase
    end

    // PC and redirect buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r       <= RESET_PC;
            pend_r     <= 1'b0;
            pend_tgt_r <= '0;
        end else begin
            pc_r       <= pc_next_s;
            pend_r     <= pend_next_s;
            pend_tgt_r <= pend_tgt_next_s;
        end
    end

    pc_addr_chk #(
        .ADDR_W (ADDR_W),
        .IM_LO  (IM_LO),
        .IM_HI  (IM_HI)
    ) u_addr_chk (
        .pc   (pc_r),
        .adel (adel)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: expected PC/pending pushed per driven cycle,
// popped and compared after the clock edge; a 16-bit instance checks wrap.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        exc_req = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc = 32'h0;

    logic [31:0] pc_a;
    logic [31:0] pc_plus4_a;
    logic        pending_a;
    logic        adel_a;
    logic [15:0] pc_b;
    logic [15:0] pc_plus4_b;
    logic        pending_b;
    logic        adel_b;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    pc_unit u_dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .br_valid  (br_valid),
        .br_target (br_target),
        .exc_req   (exc_req),
        .eret      (eret),
        .epc       (epc),
        .PC        (pc_a),
        .pc_plus4  (pc_plus4_a),
        .pending   (pending_a),
        .adel      (adel_a)
    );

    pc_unit #(.ADDR_W(16)) u_dut16 (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .br_valid  (br_valid),
        .br_target (br_target[15:0]),
        .exc_req   (exc_req),
        .eret      (eret),
        .epc       (epc[15:0]),
        .PC        (pc_b),
        .pc_plus4  (pc_plus4_b),
        .pending   (pending_b),
        .adel      (adel_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic ref_adel(input logic [31:0] p);
        return (p[1:0] != 2'b00) || (p < 32'h0000_3000) || (p > 32'h0000_6FFC);
    endfunction

    // Drive one cycle of inputs, push its expected outcome, compare after the edge.
    task automatic step(input string tag, input logic rst, input logic st,
                        input logic bv, input logic [31:0] bt,
                        input logic ex, input logic er, input logic [31:0] ep,
                        input logic [31:0] exp_pc, input logic exp_pend);
        exp_t e;
        @(negedge clk);
        reset     = rst;
        stall     = st;
        br_valid  = bv;
        br_target = bt;
        exc_req   = ex;
        eret      = er;
        epc       = ep;
        sb_q.push_back('{pc: exp_pc, pend: exp_pend});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({tag, ".pc"},   pc_a, e.pc);
        check({tag, ".pend"}, {31'd0, pending_a}, {31'd0, e.pend});
        check({tag, ".p4"},   pc_plus4_a, e.pc + 32'd4);
        check({tag, ".adel"}, {31'd0, adel_a}, {31'd0, ref_adel(e.pc)});
    endtask

    initial begin
        // reset and free-running sequence
        step("rst",   1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_3000, 1'b0);
        check("rst16.pc", {16'd0, pc_b}, 32'h0000_3000);
        step("seq1",  1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_3004, 1'b0);
        step("seq2",  1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_3008, 1'b0);
        step("seq3",  1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_300C, 1'b0);
        step("seq4",  1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_3010, 1'b0);
        // branch under stall is buffered, applied on release
        step("bst0",  1'b0, 1'b1, 1'b1, 32'h0000_3100, 1'b0, 1'b0, 32'h0, 32'h0000_3010, 1'b1);
        step("bst1",  1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_3010, 1'b1);
        step("bst2",  1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_3010, 1'b1);
        step("brel",  1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_3100, 1'b0);
        // latest redirect wins in the release cycle
        step("lw0",   1'b0, 1'b1, 1'b1, 32'h0000_3100, 1'b0, 1'b0, 32'h0, 32'h0000_3100, 1'b1);
        step("lw1",   1'b0, 1'b0, 1'b1, 32'h0000_3200, 1'b0, 1'b0, 32'h0, 32'h0000_3200, 1'b0);
        // overwrite while stalled, then release
        step("ow0",   1'b0, 1'b1, 1'b1, 32'h0000_3400, 1'b0, 1'b0, 32'h0, 32'h0000_3200, 1'b1);
        step("ow1",   1'b0, 1'b1, 1'b1, 32'h0000_3500, 1'b0, 1'b0, 32'h0, 32'h0000_3200, 1'b1);
        step("ow2",   1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_3500, 1'b0);
        // exception beats eret, stall and pending; pending is dropped
        step("ex0",   1'b0, 1'b1, 1'b1, 32'h0000_3300, 1'b0, 1'b0, 32'h0, 32'h0000_3500, 1'b1);
        step("ex1",   1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_3020, 32'h0000_4180, 1'b0);
        step("er0",   1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_3024, 32'h0000_3024, 1'b0);
        step("er1",   1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_3028, 1'b0);
        // eret ignores stall and clears pending
        step("es0",   1'b0, 1'b1, 1'b1, 32'h0000_3600, 1'b0, 1'b0, 32'h0, 32'h0000_3028, 1'b1);
        step("es1",   1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_3040, 32'h0000_3040, 1'b0);
        step("es2",   1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_3044, 1'b0);
        // address error flag does not alter sequencing
        step("ad0",   1'b0, 1'b0, 1'b1, 32'h0000_3002, 1'b0, 1'b0, 32'h0, 32'h0000_3002, 1'b0);
        step("ad1",   1'b0, 1'b0, 1'b1, 32'h0000_7000, 1'b0, 1'b0, 32'h0, 32'h0000_7000, 1'b0);
        step("ad2",   1'b0, 1'b0, 1'b1, 32'h0000_6FFC, 1'b0, 1'b0, 32'h0, 32'h0000_6FFC, 1'b0);
        step("ad3",   1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_7000, 1'b0);
        step("ad4",   1'b0, 1'b0, 1'b1, 32'h0000_2FFC, 1'b0, 1'b0, 32'h0, 32'h0000_2FFC, 1'b0);
        // reset overrides a pending redirect
        step("rp0",   1'b0, 1'b1, 1'b1, 32'h0000_3700, 1'b0, 1'b0, 32'h0, 32'h0000_2FFC, 1'b1);
        step("rp1",   1'b1, 1'b0, 1'b1, 32'h0000_3800, 1'b1, 1'b0, 32'h0, 32'h0000_3000, 1'b0);
        step("rp2",   1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_3004, 1'b0);
        // 16-bit instance wraps from 0xFFFC to 0x0000
        step("w0",    1'b0, 1'b0, 1'b1, 32'h0000_FFFC, 1'b0, 1'b0, 32'h0, 32'h0000_FFFC, 1'b0);
        check("w0_16.pc", {16'd0, pc_b}, 32'h0000_FFFC);
        check("w0_16.p4", {16'd0, pc_plus4_b}, 32'h0000_0000);
        step("w1",    1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0001_0000, 1'b0);
        check("w1_16.pc", {16'd0, pc_b}, 32'h0000_0000);
        check("w1_16.adel", {31'd0, adel_b}, 32'h0000_0001);
        if (sb_q.size() != 0) begin
            check("sb_empty", sb_q.size(), 32'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
